// File: rtl/bias_pkg.sv
// Shared widths and FSM encoding for the bias memory write path.
package bias_pkg;

  localparam int unsigned BIAS_CHANNEL_WIDTH = 288;
  localparam int unsigned IN_WIDTH           = 32;
  localparam int unsigned WORDS_PER_LINE     = BIAS_CHANNEL_WIDTH / IN_WIDTH;
  localparam int unsigned RD_ADDR_DEPTH      = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bias_word_packer.sv
// Collects WORDS stream words into one line, word 0 in the least significant slot.
module bias_word_packer #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [WORD_W-1:0]       word_in,
  input  logic                    word_en,
  output logic [WORD_W*WORDS-1:0] line_out,
  output logic                    line_full
);

  localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [CNT_W-1:0]        word_cnt;
  logic [WORD_W*WORDS-1:0] pack_q;

  // line_out already includes the word being accepted, so the finished line
  // is available on the same edge that takes the last word.
  always_comb begin
    line_out = pack_q;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (word_en && (word_cnt == CNT_W'(k))) begin
        line_out[k*WORD_W +: WORD_W] = word_in;
      end
    end
  end

  assign line_full = word_en && (word_cnt == CNT_W'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word_cnt <= '0;
      pack_q   <= '0;
    end else if (word_en) begin
      pack_q   <= line_out;
      word_cnt <= line_full ? '0 : word_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bias_mem_loader.sv
// Packs a 32-bit word stream into bias lines and writes them to the bias memory from address 0.
module bias_mem_loader #(
  parameter int unsigned BIAS_CHANNEL_WIDTH = 288,
  parameter int unsigned RD_ADDR_DEPTH      = 9,
  parameter int unsigned IN_WIDTH           = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [RD_ADDR_DEPTH:0]        line_count,
  input  logic [IN_WIDTH-1:0]           s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          mem_wr_en,
  output logic [RD_ADDR_DEPTH-1:0]      mem_addr_wr,
  output logic [BIAS_CHANNEL_WIDTH-1:0] mem_data_wr,
  output logic                          load_busy,
  output logic                          load_done
);

  import bias_pkg::*;

  localparam int unsigned WORDS = BIAS_CHANNEL_WIDTH / IN_WIDTH;
  localparam logic [RD_ADDR_DEPTH:0] MAX_LINES = {1'b1, {RD_ADDR_DEPTH{1'b0}}};

  if (BIAS_CHANNEL_WIDTH % IN_WIDTH != 0) begin : g_width_check
    $error("BIAS_CHANNEL_WIDTH must be a multiple of IN_WIDTH");
  end

  state_t                        state_q, state_d;
  logic [RD_ADDR_DEPTH:0]        count_q;
  logic [RD_ADDR_DEPTH-1:0]      line_addr_q;
  logic                          accept;
  logic                          pack_clr;
  logic                          line_full;
  logic                          last_line;
  logic [BIAS_CHANNEL_WIDTH-1:0] line_next;

  assign accept    = s_valid & s_ready;
  assign last_line = ({1'b0, line_addr_q} == (count_q - 1'b1));

  bias_word_packer #(
    .WORD_W (IN_WIDTH),
    .WORDS  (WORDS)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pack_clr),
    .word_in   (s_data),
    .word_en   (accept),
    .line_out  (line_next),
    .line_full (line_full)
  );

  always_comb begin
    state_d  = state_q;
    pack_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (line_count != '0) begin
            state_d  = FILL;
            pack_clr = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      FILL: begin
        if (line_full) state_d = WRITE;
      end
      WRITE: begin
        if (last_line) begin
          state_d = DONE;
        end else begin
          state_d  = FILL;
          pack_clr = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      line_addr_q <= '0;
      s_ready     <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr_wr <= '0;
      mem_data_wr <= '0;
      load_busy   <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready   <= (state_d == FILL);
      mem_wr_en <= (state_d == WRITE);
      load_busy <= (state_d == FILL) || (state_d == WRITE);
      load_done <= (state_d == DONE);
      if (state_q == IDLE && start) begin
        count_q     <= (line_count > MAX_LINES) ? MAX_LINES : line_count;
        line_addr_q <= '0;
      end
      if (state_q == WRITE && !last_line) begin
        line_addr_q <= line_addr_q + 1'b1;
      end
      if (state_q == FILL && state_d == WRITE) begin
        mem_addr_wr <= line_addr_q;
        mem_data_wr <= line_next;
      end
    end
  end

endmodule

// File: tb/tb_bias_mem_loader.sv
// Scoreboard bench: driver pushes expected line writes/done events, monitor pops and compares.
module tb_bias_mem_loader;

  localparam int DW  = 288;
  localparam int AW  = 9;
  localparam int WW  = 32;
  localparam int WPL = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   line_count;
  logic [WW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr_wr;
  logic [DW-1:0] mem_data_wr;
  logic          load_busy;
  logic          load_done;

  bias_mem_loader #(
    .BIAS_CHANNEL_WIDTH (DW),
    .RD_ADDR_DEPTH      (AW),
    .IN_WIDTH           (WW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .line_count  (line_count),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_addr_wr (mem_addr_wr),
    .mem_data_wr (mem_data_wr),
    .load_busy   (load_busy),
    .load_done   (load_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  typedef struct {
    int lines;
    int start_cyc;
  } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  int    last_wr_cyc = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not matched by expectation", name);
  endtask

  // Monitor: every write strobe and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_en) begin
        chk("ready_low_in_write", {287'd0, s_ready}, '0);
        if (wr_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("write_addr", {279'd0, mem_addr_wr}, {279'd0, e.addr});
          chk("write_data", mem_data_wr, e.data);
        end
        last_wr_cyc = cyc;
      end
      if (load_done) begin
        chk("busy_low_at_done", {287'd0, load_busy}, '0);
        if (done_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          done_t d;
          d = done_q.pop_front();
          if (d.lines > 0) begin
            chk("done_after_last_write", DW'(cyc - last_wr_cyc), DW'(1));
            chk("lines_remaining_at_done", DW'(wr_q.size()), '0);
          end else begin
            chk("done_after_start", DW'(cyc - d.start_cyc), DW'(1));
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] pack_line(input logic [WW-1:0] w[$], input int base);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < WPL; k++) r[k*WW +: WW] = w[base + k];
    return r;
  endfunction

  // vmode: 0 continuous valid, 1 toggling valid, 2 random valid.
  task automatic load(input int n, input int feed, input bit incr, input int vmode, input bit restart);
    logic [WW-1:0] words[$];
    int  c;
    int  idx;
    int  guard;
    bit  fire;
    bit  tog;
    bit  pulsed;
    c = (n > 512) ? 512 : n;
    for (int i = 0; i < feed; i++) words.push_back(incr ? WW'(i) : WW'($urandom));
    for (int l = 0; l < c; l++) begin
      if (WPL * (l + 1) <= feed) wr_q.push_back('{addr: AW'(l), data: pack_line(words, WPL * l)});
    end

    @(posedge clk);
    #1;
    start      = 1'b1;
    line_count = (AW + 1)'(n);
    if (feed == WPL * c) done_q.push_back('{lines: c, start_cyc: cyc});
    @(posedge clk);
    #1;
    start = 1'b0;

    if (c == 0) begin
      int rdy;
      rdy = 0;
      @(negedge clk);
      chk("busy_zero_count", {287'd0, load_busy}, '0);
      for (int i = 0; i < 4; i++) begin
        if (s_ready) rdy++;
        @(negedge clk);
      end
      chk("ready_never_high", DW'(rdy), '0);
    end else begin
      idx    = 0;
      guard  = 0;
      tog    = 1'b1;
      pulsed = 1'b0;
      s_valid = (feed > 0);
      s_data  = (feed > 0) ? words[0] : '0;
      while (idx < feed && guard < 20000) begin
        @(negedge clk);
        if (guard == 0) chk("busy_after_start", {287'd0, load_busy}, DW'(1));
        fire = s_valid && s_ready;
        @(posedge clk);
        #1;
        guard++;
        if (fire) idx++;
        start = 1'b0;
        if (restart && idx == 4 && !pulsed) begin
          start      = 1'b1;
          line_count = 10'd5;
          pulsed     = 1'b1;
        end
        tog = ~tog;
        case (vmode)
          0:       s_valid = (idx < feed);
          1:       s_valid = (idx < feed) && tog;
          default: s_valid = (idx < feed) && ($urandom_range(3) != 0);
        endcase
        s_data = (idx < feed) ? words[idx] : '0;
      end
      s_valid = 1'b0;
      start   = 1'b0;
      if (idx < feed) fail_now("feed_timeout");
    end

    if (feed == WPL * c) begin
      int g;
      g = 0;
      while (done_q.size() != 0 && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (done_q.size() != 0) begin
        fail_now("done_timeout");
        done_q.delete();
        wr_q.delete();
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    line_count = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_s_ready",   {287'd0, s_ready},   '0);
    chk("reset_wr_en",     {287'd0, mem_wr_en}, '0);
    chk("reset_addr",      {279'd0, mem_addr_wr}, '0);
    chk("reset_data",      mem_data_wr,         '0);
    chk("reset_busy_done", {286'd0, load_busy, load_done}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    load(1, 9, 1'b1, 0, 1'b0);
    load(3, 27, 1'b1, 1, 1'b0);
    load(0, 0, 1'b0, 0, 1'b0);
    load(600, 512 * WPL, 1'b0, 0, 1'b0);

    // Reset after one full line plus five words of the next.
    load(3, WPL + 5, 1'b0, 2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_s_ready", {287'd0, s_ready},     '0);
    chk("midrst_wr_en",   {287'd0, mem_wr_en},   '0);
    chk("midrst_addr",    {279'd0, mem_addr_wr}, '0);
    chk("midrst_data",    mem_data_wr,           '0);
    chk("midrst_busy",    {287'd0, load_busy},   '0);
    chk("midrst_done",    {287'd0, load_done},   '0);
    chk("midrst_pending", DW'(wr_q.size()),      '0);
    repeat (5) @(negedge clk);
    load(2, 2 * WPL, 1'b0, 2, 1'b0);

    load(2, 2 * WPL, 1'b0, 0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 5);
      load(n, WPL * n, 1'b0, 2, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("final_pending_writes", DW'(wr_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
